// File: rtl/seg_disp_sel.sv
// rtl/seg_disp_sel.sv - 7-seg display source selector with timed peek override and tune-digit blinking
// Optional build macro: SEG_LEADZERO_EN adds leading-zero suppression to blank_mask.
module seg_disp_sel #(
    parameter int                 DIGITS     = 5,
    parameter int                 NSRC       = 4,
    parameter int                 SRC_W      = 2,
    parameter logic [8*SRC_W-1:0] SRC_MAP    = 16'h0F00,
    parameter int                 PEEK_SRC   = 1,
    parameter int                 HOLD_TICKS = 3000,
    parameter int                 BLINK_DIV  = 500,
    localparam int                TD_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int                WORD_W     = DIGITS * 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             sys_status,
    input  logic [NSRC*WORD_W-1:0] src_data,
    input  logic                   tick,
    input  logic                   peek_req,
    input  logic                   tune_active,
    input  logic [TD_W-1:0]        tune_digit,
    output logic [WORD_W-1:0]      seg_data,
    output logic [DIGITS-1:0]      blank_mask,
    output logic [SRC_W-1:0]       src_sel,
    output logic                   peek_active
);

    localparam int HC_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int NSEL = 2 ** SRC_W;
    localparam logic [HC_W-1:0]  HOLD_LOAD  = HC_W'(HOLD_TICKS - 1);
    localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_DIV - 1);
    localparam logic [SRC_W-1:0] PEEK_SEL   = SRC_W'(PEEK_SRC);

    typedef enum logic {
        ST_IDLE,
        ST_PEEK
    } peek_state_t;

    peek_state_t       state_q, state_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [2:0]        status_q;
    logic [BC_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic              blink_off_q, blink_off_d;
    logic              tune_active_q;
    logic [TD_W-1:0]   tune_digit_q;

    logic [SRC_W-1:0]  map_tbl [8];
    logic [WORD_W-1:0] src_word [NSEL];
    logic [SRC_W-1:0]  map_raw;
    logic [SRC_W-1:0]  map_sel;
    logic [SRC_W-1:0]  eff_sel;
    logic [WORD_W-1:0] sel_word;
    logic [DIGITS-1:0] edit_dig;
    logic [DIGITS-1:0] blink_mask;
    logic [DIGITS-1:0] lz_mask;

    for (genvar g = 0; g < 8; g++) begin : g_map
        assign map_tbl[g] = SRC_MAP[g*SRC_W +: SRC_W];
    end

    // Unused select codes read as an all-zero word so eff_sel can index freely.
    for (genvar g = 0; g < NSEL; g++) begin : g_src
        if (g < NSRC) begin : g_used
            assign src_word[g] = src_data[g*WORD_W +: WORD_W];
        end else begin : g_pad
            assign src_word[g] = '0;
        end
    end

    assign map_raw = map_tbl[sys_status];
    assign map_sel = (int'(map_raw) >= NSRC) ? '0 : map_raw;

    // Peek override: a status change wins over retrigger, retrigger wins over expiry.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (peek_req && (map_sel == '0)) begin
                    state_d = ST_PEEK;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_PEEK: begin
                if (sys_status != status_q) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else if (peek_req) begin
                    hold_d = HOLD_LOAD;
                end else if (tick) begin
                    if (hold_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - HC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Output registers follow the next peek state so seg_data and peek_active move together.
    assign eff_sel  = (state_d == ST_PEEK) ? PEEK_SEL : map_sel;
    assign sel_word = src_word[eff_sel];

    // A newly selected digit (or fresh edit) starts in the visible phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (!tune_active || !tune_active_q || (tune_digit != tune_digit_q)) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BC_W'(1);
            end
        end
    end

    always_comb begin
        edit_dig   = '0;
        blink_mask = '0;
        for (int i = 0; i < DIGITS; i++) begin
            edit_dig[i]   = tune_active && (tune_digit == TD_W'(i));
            blink_mask[i] = edit_dig[i] && blink_off_d;
        end
    end

`ifdef SEG_LEADZERO_EN
    logic lz_run;

    // Walk down from the MS digit while digits stay zero; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && (sel_word[i*4 +: 4] == 4'd0);
            lz_mask[i] = lz_run && !edit_dig[i];
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            status_q      <= '0;
            blink_cnt_q   <= '0;
            blink_off_q   <= 1'b0;
            tune_active_q <= 1'b0;
            tune_digit_q  <= '0;
            seg_data      <= '0;
            blank_mask    <= '0;
            src_sel       <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            status_q      <= sys_status;
            blink_cnt_q   <= blink_cnt_d;
            blink_off_q   <= blink_off_d;
            tune_active_q <= tune_active;
            tune_digit_q  <= tune_digit;
            seg_data      <= sel_word;
            blank_mask    <= blink_mask | lz_mask;
            src_sel       <= eff_sel;
        end
    end

    assign peek_active = (state_q == ST_PEEK);

endmodule
